// File: rtl/mprj_io_seq_checker.sv
// ----------------------------------------------------------------------------
// mprj_io_seq_checker
//
// On-chip monitor for an ordered sequence of masked patterns on a user IO bus.
// A small pattern/mask table is loaded while the checker is not running.
// start_i arms a run, which walks the table one step at a time. Each step
// waits for the observed bus to match that step's masked pattern. The run
// ends with a sticky PASS verdict once the last step matches. It ends with a
// sticky FAIL verdict if the optional cycle budget runs out first.
//
// Optional feature (compile-time macro MPRJ_SEQ_STABLE_EN):
//   When defined, a step advances only after its match has held for
//   STABLE_CYC consecutive cycles. Any mismatch restarts that hold count.
//   When undefined, a single matching cycle advances the step, and no hold
//   counter is built.
//
// Ports
//   wb_clk_i     in   clock
//   wb_rst_i     in   synchronous active-high reset
//   obs_i        in   [WIDTH-1:0]  observed bus
//   load_en_i    in   write one table entry (ignored while running)
//   load_idx_i   in   [IDX_W-1:0]  table entry index
//   load_pat_i   in   [WIDTH-1:0]  expected value
//   load_mask_i  in   [WIDTH-1:0]  1 = compare bit, 0 = don't care
//   num_steps_i  in   [NS_W-1:0]   steps to check, sampled on start_i
//   timeout_i    in   [TMO_W-1:0]  cycle budget, sampled on start_i, 0 = none
//   start_i      in   arm / re-arm the checker from any state
//   busy_o       out  run in progress
//   pass_o       out  all steps matched (sticky until next start/reset)
//   fail_o       out  budget exhausted before completion (sticky)
//   step_o       out  [IDX_W-1:0]  current step; frozen at the stalled step on fail
// ----------------------------------------------------------------------------
module mprj_io_seq_checker #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 4,
  parameter int TMO_W      = 16,
  parameter int STABLE_CYC = 2,
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NS_W      = $clog2(DEPTH + 1)
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] obs_i,
  input  logic             load_en_i,
  input  logic [IDX_W-1:0] load_idx_i,
  input  logic [WIDTH-1:0] load_pat_i,
  input  logic [WIDTH-1:0] load_mask_i,
  input  logic [NS_W-1:0]  num_steps_i,
  input  logic [TMO_W-1:0] timeout_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic [IDX_W-1:0] step_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] step_q, step_d;
  logic [TMO_W-1:0] count_q, count_d;
  logic [NS_W-1:0]  nsteps_q, nsteps_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [WIDTH-1:0] pat_q  [DEPTH];
  logic [WIDTH-1:0] mask_q [DEPTH];

  logic             match;
  logic             step_ok;
  logic             last_step;
  logic             tmo_expire;
  logic [NS_W-1:0]  nsteps_clamped;
  logic             table_wr_ok;

  // --------------------------------------------------------------------------
  // Pattern / mask table. Entries are plain registers, not block RAM.
  // They need a reset value, and the current step is read
  // combinationally in the same cycle.
  // --------------------------------------------------------------------------
  assign table_wr_ok = load_en_i && (state_q != RUN);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] pat_d;
      logic [WIDTH-1:0] mask_d;

      always_comb begin
        pat_d  = pat_q[gi];
        mask_d = mask_q[gi];
        if (table_wr_ok && (load_idx_i == IDX_W'(gi))) begin
          pat_d  = load_pat_i;
          mask_d = load_mask_i;
        end
      end

      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          pat_q[gi]  <= '0;
          mask_q[gi] <= '0;
        end else begin
          pat_q[gi]  <= pat_d;
          mask_q[gi] <= mask_d;
        end
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Step match and qualification
  // --------------------------------------------------------------------------
  assign match = ((obs_i ^ pat_q[step_q]) & mask_q[step_q]) == '0;

`ifdef MPRJ_SEQ_STABLE_EN
  // The hold counter counts matching cycles of the current step, up to
  // STABLE_CYC-1. The step advances on the cycle that completes the run of
  // STABLE_CYC consecutive matches.
  localparam int HOLD_W   = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam int HOLD_MAX = (STABLE_CYC > 1) ? STABLE_CYC - 1 : 0;

  logic [HOLD_W-1:0] hold_q, hold_d;

  assign step_ok = match && (hold_q == HOLD_W'(HOLD_MAX));

  always_comb begin
    hold_d = hold_q;
    if (start_i) begin
      hold_d = '0;
    end else if (state_q == RUN) begin
      if (!match || step_ok) begin
        hold_d = '0;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  // STABLE_CYC only matters in the hold build. It is referenced here so
  // both builds share one parameter list. The term is always true.
  assign step_ok = match && (STABLE_CYC >= 0);
`endif

  // A zero-extended step is compared against num_steps-1. nsteps_q is never
  // 0 while in RUN, because a zero-step run goes straight to PASS.
  assign last_step  = ({{(NS_W > IDX_W ? NS_W - IDX_W : 0){1'b0}}, step_q} ==
                       (nsteps_q - NS_W'(1)));
  assign tmo_expire = (tmo_q != '0) && (count_q == (tmo_q - TMO_W'(1)));

  assign nsteps_clamped = (num_steps_i > NS_W'(DEPTH)) ? NS_W'(DEPTH) : num_steps_i;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    count_d  = count_q;
    nsteps_d = nsteps_q;
    tmo_d    = tmo_q;

    if (start_i) begin
      // A re-arm takes priority over whatever the current run is doing.
      step_d   = '0;
      count_d  = '0;
      nsteps_d = nsteps_clamped;
      tmo_d    = timeout_i;
      state_d  = (nsteps_clamped == '0) ? PASS : RUN;
    end else begin
      case (state_q)
        RUN: begin
          count_d = count_q + TMO_W'(1);
          if (step_ok && last_step) begin
            // The final match also wins over an expiring budget in this cycle.
            state_d = PASS;
          end else if (tmo_expire) begin
            // step_o stays on the step that failed to complete.
            state_d = FAIL;
          end else if (step_ok) begin
            step_d = step_q + IDX_W'(1);
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      step_q   <= '0;
      count_q  <= '0;
      nsteps_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      count_q  <= count_d;
      nsteps_q <= nsteps_d;
      tmo_q    <= tmo_d;
    end
  end

  // The verdicts come straight from the state, so they are sticky and
  // mutually exclusive.
  assign busy_o = (state_q == RUN);
  assign pass_o = (state_q == PASS);
  assign fail_o = (state_q == FAIL);
  assign step_o = step_q;

endmodule

// File: tb/tb_mprj_io_seq_checker.sv
// ----------------------------------------------------------------------------
// tb_mprj_io_seq_checker
//
// Directed-vector bench for mprj_io_seq_checker with hand-computed expected
// values. It prints one line per compared vector.
// ----------------------------------------------------------------------------
module tb_mprj_io_seq_checker;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int TMO_W = 16;
  localparam int IDX_W = 2;
  localparam int NS_W  = 3;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b1;
  logic [WIDTH-1:0] obs_i = '0;
  logic             load_en_i = 1'b0;
  logic [IDX_W-1:0] load_idx_i = '0;
  logic [WIDTH-1:0] load_pat_i = '0;
  logic [WIDTH-1:0] load_mask_i = '0;
  logic [NS_W-1:0]  num_steps_i = '0;
  logic [TMO_W-1:0] timeout_i = '0;
  logic             start_i = 1'b0;
  logic             busy_o;
  logic             pass_o;
  logic             fail_o;
  logic [IDX_W-1:0] step_o;

  int vectors    = 0;
  int miscompares = 0;

  mprj_io_seq_checker #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .TMO_W(TMO_W), .STABLE_CYC(2)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .obs_i      (obs_i),
    .load_en_i  (load_en_i),
    .load_idx_i (load_idx_i),
    .load_pat_i (load_pat_i),
    .load_mask_i(load_mask_i),
    .num_steps_i(num_steps_i),
    .timeout_i  (timeout_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .pass_o     (pass_o),
    .fail_o     (fail_o),
    .step_o     (step_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end else begin
      $display("ok   %s: %0h", tag, act);
    end
  endtask

  // One clock, then settle 1 ns past the edge for driving and sampling.
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic load(input logic [IDX_W-1:0] idx, input logic [WIDTH-1:0] pat,
                      input logic [WIDTH-1:0] mask);
    load_en_i   = 1'b1;
    load_idx_i  = idx;
    load_pat_i  = pat;
    load_mask_i = mask;
    tick();
    load_en_i   = 1'b0;
  endtask

  task automatic start_run(input logic [NS_W-1:0] ns, input logic [TMO_W-1:0] tmo);
    num_steps_i = ns;
    timeout_i   = tmo;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  initial begin
    // 1: reset
    wb_rst_i = 1'b1;
    tick();
    tick();
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_pass", 32'(pass_o), 32'd0);
    check_eq("rst_fail", 32'(fail_o), 32'd0);
    check_eq("rst_step", 32'(step_o), 32'd0);
    wb_rst_i = 1'b0;
    tick();

    load(2'd0, 16'h2100, 16'hFF00);
    load(2'd1, 16'h372C, 16'hFFFF);
    load(2'd2, 16'hA5F0, 16'hFFFF);

`ifndef MPRJ_SEQ_STABLE_EN
    // 2: pass path
    obs_i = 16'h0000;
    start_run(3'd3, 16'd1000);
    check_eq("pass_busy_run", 32'(busy_o), 32'd1);
    check_eq("pass_step0", 32'(step_o), 32'd0);
    obs_i = 16'h21AB; tick();
    check_eq("pass_step1", 32'(step_o), 32'd1);
    obs_i = 16'h372C; tick();
    check_eq("pass_step2", 32'(step_o), 32'd2);
    obs_i = 16'hA5F0; tick();
    check_eq("pass_pass", 32'(pass_o), 32'd1);
    check_eq("pass_busy", 32'(busy_o), 32'd0);
    check_eq("pass_fail", 32'(fail_o), 32'd0);

    // 3: timeout after exactly 50 RUN cycles, stalled on step 1
    obs_i = 16'h0000;
    start_run(3'd3, 16'd50);
    check_eq("tmo_pass_cleared", 32'(pass_o), 32'd0);
    obs_i = 16'h21AB;
    repeat (49) tick();
    check_eq("tmo_fail_at49", 32'(fail_o), 32'd0);
    check_eq("tmo_busy_at49", 32'(busy_o), 32'd1);
    tick();
    check_eq("tmo_fail_at50", 32'(fail_o), 32'd1);
    check_eq("tmo_step", 32'(step_o), 32'd1);
    check_eq("tmo_busy", 32'(busy_o), 32'd0);
    check_eq("tmo_pass", 32'(pass_o), 32'd0);

    // 4a: zero steps -> PASS one cycle after start
    start_run(3'd0, 16'd1000);
    check_eq("zero_pass", 32'(pass_o), 32'd1);
    check_eq("zero_fail", 32'(fail_o), 32'd0);
    check_eq("zero_busy", 32'(busy_o), 32'd0);

    // 4b: final match on the last budget cycle wins
    obs_i = 16'h0000;
    start_run(3'd1, 16'd3);
    tick();
    tick();
    obs_i = 16'h21AB; tick();
    check_eq("edge_pass", 32'(pass_o), 32'd1);
    check_eq("edge_fail", 32'(fail_o), 32'd0);
    // same budget without the match fails on that cycle
    obs_i = 16'h0000;
    start_run(3'd1, 16'd3);
    tick();
    tick();
    check_eq("edge_nomatch_fail_early", 32'(fail_o), 32'd0);
    tick();
    check_eq("edge_nomatch_fail", 32'(fail_o), 32'd1);

    // 5a: restart mid-run clears the step and the budget counter
    obs_i = 16'h0000;
    start_run(3'd3, 16'd10);
    obs_i = 16'h21AB; tick();
    check_eq("rst_mid_step1", 32'(step_o), 32'd1);
    obs_i = 16'h0000;
    repeat (3) tick();
    start_run(3'd3, 16'd10);
    check_eq("restart_step", 32'(step_o), 32'd0);
    check_eq("restart_busy", 32'(busy_o), 32'd1);
    repeat (9) tick();
    check_eq("restart_fail_at9", 32'(fail_o), 32'd0);
    tick();
    check_eq("restart_fail_at10", 32'(fail_o), 32'd1);

    // 5b: writes during RUN are ignored, and a zero budget never expires
    obs_i = 16'h0000;
    start_run(3'd3, 16'd0);
    load(2'd0, 16'hFFFF, 16'hFFFF);
    repeat (70) tick();
    check_eq("notmo_busy", 32'(busy_o), 32'd1);
    check_eq("notmo_fail", 32'(fail_o), 32'd0);
    obs_i = 16'h21AB; tick();
    obs_i = 16'h372C; tick();
    obs_i = 16'hA5F0; tick();
    check_eq("guard_pass", 32'(pass_o), 32'd1);

    // write and start in the same cycle: the run uses the new entry
    obs_i       = 16'h0000;
    load_en_i   = 1'b1;
    load_idx_i  = 2'd2;
    load_pat_i  = 16'h1234;
    load_mask_i = 16'hFFFF;
    start_run(3'd3, 16'd0);
    load_en_i   = 1'b0;
    obs_i = 16'h21AB; tick();
    obs_i = 16'h372C; tick();
    obs_i = 16'h1234; tick();
    check_eq("wrstart_pass", 32'(pass_o), 32'd1);

    // num_steps above DEPTH clamps to DEPTH; entry 3 is still all don't-care
    obs_i = 16'h0000;
    start_run(3'd7, 16'd0);
    obs_i = 16'h21AB; tick();
    obs_i = 16'h372C; tick();
    obs_i = 16'h1234; tick();
    check_eq("clamp_step3", 32'(step_o), 32'd3);
    check_eq("clamp_not_yet", 32'(pass_o), 32'd0);
    obs_i = 16'h0000; tick();
    check_eq("clamp_pass", 32'(pass_o), 32'd1);
`else
    // 6: hold-qualified stepping with STABLE_CYC = 2
    obs_i = 16'h0000;
    start_run(3'd3, 16'd0);
    obs_i = 16'h21AB; tick();
    check_eq("stab_step0_hold1", 32'(step_o), 32'd0);
    tick();
    check_eq("stab_step1", 32'(step_o), 32'd1);
    obs_i = 16'h372C; tick();
    obs_i = 16'h0000; tick();
    check_eq("stab_glitch", 32'(step_o), 32'd1);
    obs_i = 16'h372C; tick();
    check_eq("stab_hold1", 32'(step_o), 32'd1);
    tick();
    check_eq("stab_step2", 32'(step_o), 32'd2);
    check_eq("stab_busy", 32'(busy_o), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
